// File: rtl/regfile_sb.sv
// Two-write-port integer register file with optional same-cycle bypass and a
// per-register busy scoreboard used by decode to stall on outstanding writes.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wb0_we,
    input  logic [AW-1:0]   wb0_addr,
    input  logic [XLEN-1:0] wb0_data,
    input  logic            wb1_we,
    input  logic [AW-1:0]   wb1_addr,
    input  logic [XLEN-1:0] wb1_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic [AW:0]     busy_cnt,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);
    localparam int NREG = 1 << AW;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     cnt_nxt;
    logic            wb0_hit, wb1_hit, iss_hit;
    logic            rs1_f0, rs1_f1, rs2_f0, rs2_f1;

    // Write-backs are masked while in reset so nothing leaks through the bypass.
    assign wb0_hit = rst_n && wb0_we && (wb0_addr != '0);
    assign wb1_hit = rst_n && wb1_we && (wb1_addr != '0);
    assign iss_hit = iss_valid && (iss_rd != '0);

    // wb1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (wb0_hit) regs[wb0_addr] <= wb0_data;
            if (wb1_hit) regs[wb1_addr] <= wb1_data;
        end
    end

    assign rs1_f0 = BYPASS && wb0_hit && (wb0_addr == rs1_addr);
    assign rs1_f1 = BYPASS && wb1_hit && (wb1_addr == rs1_addr);
    assign rs2_f0 = BYPASS && wb0_hit && (wb0_addr == rs2_addr);
    assign rs2_f1 = BYPASS && wb1_hit && (wb1_addr == rs2_addr);

    always_comb begin
        if (rs1_addr == '0)  rs1_data = '0;
        else if (rs1_f1)     rs1_data = wb1_data;
        else if (rs1_f0)     rs1_data = wb0_data;
        else                 rs1_data = regs[rs1_addr];
    end

    always_comb begin
        if (rs2_addr == '0)  rs2_data = '0;
        else if (rs2_f1)     rs2_data = wb1_data;
        else if (rs2_f0)     rs2_data = wb0_data;
        else                 rs2_data = regs[rs2_addr];
    end

    assign rs1_busy = (rs1_addr != '0) && busy[rs1_addr] && !(rs1_f0 || rs1_f1);
    assign rs2_busy = (rs2_addr != '0) && busy[rs2_addr] && !(rs2_f0 || rs2_f1);
    assign dbg_data = regs[dbg_addr];

    // Issue is applied after the clears: a new producer outranks a retiring one.
    always_comb begin
        busy_nxt = busy;
        if (wb0_hit) busy_nxt[wb0_addr] = 1'b0;
        if (wb1_hit) busy_nxt[wb1_addr] = 1'b0;
        if (iss_hit) busy_nxt[iss_rd]   = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one instance with bypass, one without, sharing stimulus
// and checked against a behavioural register/scoreboard model.
module tb_regfile_sb;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [AW-1:0]   rs1_addr, rs2_addr, wb0_addr, wb1_addr, iss_rd, dbg_addr;
    logic [XLEN-1:0] wb0_data, wb1_data;
    logic            wb0_we, wb1_we, iss_valid;

    logic [XLEN-1:0] rs1_data_b, rs2_data_b, dbg_data_b, rs1_data_n, rs2_data_n, dbg_data_n;
    logic            rs1_busy_b, rs2_busy_b, rs1_busy_n, rs2_busy_n;
    logic [AW:0]     busy_cnt_b, busy_cnt_n;

    int n_tests = 0;
    int n_fail  = 0;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];

    regfile_sb #(.XLEN(XLEN), .AW(AW), .BYPASS(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data_b), .rs2_data(rs2_data_b),
        .rs1_busy(rs1_busy_b), .rs2_busy(rs2_busy_b),
        .wb0_we(wb0_we), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_we(wb1_we), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busy_cnt(busy_cnt_b), .dbg_addr(dbg_addr), .dbg_data(dbg_data_b)
    );

    regfile_sb #(.XLEN(XLEN), .AW(AW), .BYPASS(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data_n), .rs2_data(rs2_data_n),
        .rs1_busy(rs1_busy_n), .rs2_busy(rs2_busy_n),
        .wb0_we(wb0_we), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_we(wb1_we), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busy_cnt(busy_cnt_n), .dbg_addr(dbg_addr), .dbg_data(dbg_data_n)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    // Architectural effect of one clock edge given the current inputs.
    function automatic void model_commit();
        if (wb0_we && wb0_addr != 0) begin
            m_regs[wb0_addr] = wb0_data;
            m_busy[wb0_addr] = 1'b0;
        end
        if (wb1_we && wb1_addr != 0) begin
            m_regs[wb1_addr] = wb1_data;
            m_busy[wb1_addr] = 1'b0;
        end
        if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    endfunction

    function automatic logic [AW:0] model_count();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
        return c[AW:0];
    endfunction

    function automatic logic [XLEN-1:0] model_read(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && wb1_we && wb1_addr == a) return wb1_data;
        if (byp && wb0_we && wb0_addr == a) return wb0_data;
        return m_regs[a];
    endfunction

    function automatic bit model_busy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && ((wb0_we && wb0_addr == a) || (wb1_we && wb1_addr == a))) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic idle_inputs();
        wb0_we = 0; wb0_addr = '0; wb0_data = '0;
        wb1_we = 0; wb1_addr = '0; wb1_data = '0;
        iss_valid = 0; iss_rd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rs1_addr = 0; rs2_addr = 0; dbg_addr = 4;
        #2 rst_n = 1'b0;
        model_reset();
        wb0_we = 1; wb0_addr = 0; wb0_data = 32'hDEADBEEF;
        wb1_we = 1; wb1_addr = 4; wb1_data = 32'h12345678;
        iss_valid = 1; iss_rd = 0; rs1_addr = 4;
        #1;
        n_tests++;
        if ({rs1_data_b, rs1_busy_b, busy_cnt_b} !== {32'h0, 1'b0, 6'd0}) begin
            n_fail++;
            $display("FAIL reset_hold_byp: got data=%h busy=%b cnt=%0d want 0/0/0", rs1_data_b, rs1_busy_b, busy_cnt_b);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        wb1_we = 0; rs1_addr = 0;
        #1;
        n_tests++;
        if ({rs1_data_b, rs1_data_n} !== 64'h0) begin
            n_fail++;
            $display("FAIL x0_write_same_cycle: got %h/%h want 0/0", rs1_data_b, rs1_data_n);
        end
        tick();
        n_tests++;
        if ({rs1_data_b, rs1_busy_b, busy_cnt_b, rs1_data_n, rs1_busy_n, busy_cnt_n} !==
            {32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0}) begin
            n_fail++;
            $display("FAIL x0_after_edge: got b=%h/%b/%0d n=%h/%b/%0d want zeros",
                     rs1_data_b, rs1_busy_b, busy_cnt_b, rs1_data_n, rs1_busy_n, busy_cnt_n);
        end
        n_tests++;
        if ({dbg_data_b, dbg_data_n} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_write_dropped: got dbg %h/%h want 0/0", dbg_data_b, dbg_data_n);
        end
        idle_inputs();
    endtask

    task automatic test_collision();
        wb0_we = 1; wb0_addr = 5; wb0_data = 32'h11111111;
        wb1_we = 1; wb1_addr = 5; wb1_data = 32'h22222222;
        rs2_addr = 5;
        #1;
        n_tests++;
        if (rs2_data_b !== 32'h22222222) begin
            n_fail++;
            $display("FAIL collision_same_cycle_byp: got %h want 22222222", rs2_data_b);
        end
        n_tests++;
        if (rs2_data_n !== 32'h0) begin
            n_fail++;
            $display("FAIL collision_same_cycle_nobyp: got %h want 00000000", rs2_data_n);
        end
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if ({rs2_data_b, rs2_data_n} !== {32'h22222222, 32'h22222222}) begin
            n_fail++;
            $display("FAIL collision_after_edge: got %h/%h want 22222222", rs2_data_b, rs2_data_n);
        end
    endtask

    task automatic test_bypass();
        wb0_we = 1; wb0_addr = 7; wb0_data = 32'hA5A5A5A5;
        rs1_addr = 7;
        #1;
        n_tests++;
        if (rs1_data_b !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL bypass_on: got %h want a5a5a5a5", rs1_data_b);
        end
        n_tests++;
        if (rs1_data_n !== 32'h0) begin
            n_fail++;
            $display("FAIL bypass_off_old: got %h want 00000000", rs1_data_n);
        end
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if ({rs1_data_b, rs1_data_n} !== {32'hA5A5A5A5, 32'hA5A5A5A5}) begin
            n_fail++;
            $display("FAIL bypass_after_edge: got %h/%h want a5a5a5a5", rs1_data_b, rs1_data_n);
        end
    endtask

    task automatic test_scoreboard();
        logic [XLEN-1:0] v = $urandom;
        iss_valid = 1; iss_rd = 3; rs1_addr = 3; dbg_addr = 3;
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if ({rs1_busy_b, busy_cnt_b, rs1_busy_n, busy_cnt_n} !== {1'b1, 6'd1, 1'b1, 6'd1}) begin
            n_fail++;
            $display("FAIL sb_issue: got b=%b/%0d n=%b/%0d want 1/1", rs1_busy_b, busy_cnt_b, rs1_busy_n, busy_cnt_n);
        end
        tick(); tick();
        wb1_we = 1; wb1_addr = 3; wb1_data = v;
        #1;
        n_tests++;
        if ({rs1_busy_b, rs1_busy_n} !== 2'b01) begin
            n_fail++;
            $display("FAIL sb_wb_same_cycle: got byp=%b nobyp=%b want 0/1", rs1_busy_b, rs1_busy_n);
        end
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if ({rs1_busy_b, busy_cnt_b, rs1_busy_n, busy_cnt_n} !== {1'b0, 6'd0, 1'b0, 6'd0}) begin
            n_fail++;
            $display("FAIL sb_retire: got b=%b/%0d n=%b/%0d want 0/0", rs1_busy_b, busy_cnt_b, rs1_busy_n, busy_cnt_n);
        end
        n_tests++;
        if ({dbg_data_b, dbg_data_n} !== {v, v}) begin
            n_fail++;
            $display("FAIL sb_dbg: got %h/%h want %h", dbg_data_b, dbg_data_n, v);
        end
    endtask

    task automatic test_issue_wb();
        iss_valid = 1; iss_rd = 9; rs2_addr = 9;
        tick();
        wb0_we = 1; wb0_addr = 9; wb0_data = 32'h99;
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if ({rs2_busy_b, busy_cnt_b, rs2_busy_n, busy_cnt_n} !== {1'b1, 6'd1, 1'b1, 6'd1}) begin
            n_fail++;
            $display("FAIL issue_wins: got b=%b/%0d n=%b/%0d want 1/1", rs2_busy_b, busy_cnt_b, rs2_busy_n, busy_cnt_n);
        end
        wb0_we = 1; wb0_addr = 9; wb0_data = 32'h9A;
        tick();
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 4; i++) begin
            iss_valid = 1; iss_rd = AW'(10 + i);
            wb0_we = 1; wb0_addr = AW'(20 + i); wb0_data = $urandom;
            tick();
        end
        idle_inputs();
        #1;
        n_tests++;
        if ({busy_cnt_b, busy_cnt_n} !== {6'd4, 6'd4}) begin
            n_fail++;
            $display("FAIL mid_reset_setup: got %0d/%0d want 4", busy_cnt_b, busy_cnt_n);
        end
        wb0_we = 1; wb0_addr = 10; wb0_data = 32'hCAFE0001;
        wb1_we = 1; wb1_addr = 20; wb1_data = 32'hCAFE0002;
        iss_valid = 1; iss_rd = 14;
        rs1_addr = 20; rs2_addr = 10; dbg_addr = 21;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy_cnt_b, busy_cnt_n, rs1_busy_b, rs2_busy_b, rs1_busy_n, rs2_busy_n} !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_reset_busy: got cnt %0d/%0d busy %b%b%b%b want 0",
                     busy_cnt_b, busy_cnt_n, rs1_busy_b, rs2_busy_b, rs1_busy_n, rs2_busy_n);
        end
        n_tests++;
        if ({rs1_data_b, rs2_data_b, dbg_data_b, rs1_data_n, rs2_data_n, dbg_data_n} !== 192'h0) begin
            n_fail++;
            $display("FAIL mid_reset_reads: got %h %h %h / %h %h %h want 0",
                     rs1_data_b, rs2_data_b, dbg_data_b, rs1_data_n, rs2_data_n, dbg_data_n);
        end
        @(posedge clk); #1;
        idle_inputs();
        model_reset();
        rst_n = 1'b1;
        dbg_addr = 20;
        #1;
        n_tests++;
        if ({dbg_data_b, dbg_data_n, busy_cnt_b, busy_cnt_n} !== {64'h0, 12'h0}) begin
            n_fail++;
            $display("FAIL mid_reset_no_land: got dbg %h/%h cnt %0d/%0d want 0",
                     dbg_data_b, dbg_data_n, busy_cnt_b, busy_cnt_n);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] lim;
        for (int c = 0; c < 400; c++) begin
            lim = ($urandom_range(0, 1) == 0) ? AW'(7) : AW'(31);
            wb0_we = 1'($urandom); wb0_addr = AW'($urandom_range(0, int'(lim))); wb0_data = $urandom;
            wb1_we = 1'($urandom); wb1_addr = AW'($urandom_range(0, int'(lim))); wb1_data = $urandom;
            iss_valid = ($urandom_range(0, 2) != 0); iss_rd = AW'($urandom_range(0, int'(lim)));
            rs1_addr = AW'($urandom_range(0, int'(lim)));
            rs2_addr = AW'($urandom_range(0, int'(lim)));
            dbg_addr = AW'($urandom_range(0, int'(lim)));
            #1;
            n_tests++;
            if ({rs1_data_b, rs2_data_b, rs1_busy_b, rs2_busy_b, dbg_data_b} !==
                {model_read(rs1_addr, 1), model_read(rs2_addr, 1), model_busy(rs1_addr, 1),
                 model_busy(rs2_addr, 1), m_regs[dbg_addr]}) begin
                n_fail++;
                $display("FAIL rand_read_byp cyc %0d: got %h %h %b %b %h want %h %h %b %b %h", c,
                         rs1_data_b, rs2_data_b, rs1_busy_b, rs2_busy_b, dbg_data_b,
                         model_read(rs1_addr, 1), model_read(rs2_addr, 1), model_busy(rs1_addr, 1),
                         model_busy(rs2_addr, 1), m_regs[dbg_addr]);
            end
            n_tests++;
            if ({rs1_data_n, rs2_data_n, rs1_busy_n, rs2_busy_n, dbg_data_n} !==
                {model_read(rs1_addr, 0), model_read(rs2_addr, 0), model_busy(rs1_addr, 0),
                 model_busy(rs2_addr, 0), m_regs[dbg_addr]}) begin
                n_fail++;
                $display("FAIL rand_read_nobyp cyc %0d: got %h %h %b %b %h want %h %h %b %b %h", c,
                         rs1_data_n, rs2_data_n, rs1_busy_n, rs2_busy_n, dbg_data_n,
                         model_read(rs1_addr, 0), model_read(rs2_addr, 0), model_busy(rs1_addr, 0),
                         model_busy(rs2_addr, 0), m_regs[dbg_addr]);
            end
            tick();
            n_tests++;
            if ({busy_cnt_b, busy_cnt_n} !== {model_count(), model_count()}) begin
                n_fail++;
                $display("FAIL rand_busy_cnt cyc %0d: got %0d/%0d want %0d", c, busy_cnt_b, busy_cnt_n, model_count());
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_collision();
        test_bypass();
        test_scoreboard();
        test_issue_wb();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
